uart_tx_fifo: RTL and testbench

//  Transmit-side byte buffer of the APB UART. It sits between the APB write

---
 rtl/uart_tx_fifo.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit-side byte queue of the APB UART.
// Bus writes are buffered in a small circular FIFO; a launch FSM pops one
// byte at a time, hands it to the transmitter with a one-cycle start pulse
// and then waits for the transmitter's busy window to open and close before
// launching the next byte.
module uart_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam int DEPTH = 1 << ADDR_W;

    // Launch FSM encoding; 3 bits wide so unused codes exist and are
    // explicitly steered back to IDLE.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BSY  = 3'd2,
        WAIT_DONE = 3'd3
    } state_t;

    state_t             state_r;
    state_t             next_state_s;

    logic [DATA_W-1:0]  mem_r [DEPTH];
    logic [ADDR_W:0]    w_ptr_r;
    logic [ADDR_W:0]    r_ptr_r;
    logic               full_s;
    logic               empty_s;
    logic               wr_accept_s;
    logic               pop_s;
    logic               tx_start_r;
    logic [DATA_W-1:0]  tx_data_r;
    logic               overflow_r;

    // Pointer MSB is the wrap flag: equal low bits with differing flags
    // means the write pointer is a full lap ahead.
    assign full_s      = (w_ptr_r[ADDR_W] != r_ptr_r[ADDR_W]) &&
                         (w_ptr_r[ADDR_W-1:0] == r_ptr_r[ADDR_W-1:0]);
    assign empty_s     = (w_ptr_r == r_ptr_r);
    assign wr_accept_s = wr_en && !full_s;

    assign full     = full_s;
    assign empty    = empty_s;
    assign count    = w_ptr_r - r_ptr_r;
    assign tx_start = tx_start_r;
    assign tx_data  = tx_data_r;
    assign overflow = overflow_r;

    // Launch FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Launch FSM next-state logic and pop decision (pops only from IDLE).
    always_comb begin
        next_state_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s && !tx_busy) begin
                    pop_s        = 1'b1;
                    next_state_s = START;
                end else begin
                    next_state_s = IDLE;
                end
            end
            START: begin
                next_state_s = WAIT_BSY;
            end
            WAIT_BSY: begin
                if (tx_busy) begin
                    next_state_s = WAIT_DONE;
                end else begin
                    next_state_s = WAIT_BSY;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WAIT_DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Storage array; deliberately not reset, stale contents are unreachable
    // because the pointers are cleared.
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            mem_r[w_ptr_r[ADDR_W-1:0]] <= data_in;
        end
    end

    // Write pointer advances on every accepted write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr_r <= {(ADDR_W+1){1'b0}};
        end else if (wr_accept_s) begin
            w_ptr_r <= w_ptr_r + {{ADDR_W{1'b0}}, 1'b1};
        end else begin
            w_ptr_r <= w_ptr_r;
        end
    end

    // Read pointer advances on every pop issued by the launch FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr_r <= {(ADDR_W+1){1'b0}};
        end else if (pop_s) begin
            r_ptr_r <= r_ptr_r + {{ADDR_W{1'b0}}, 1'b1};
        end else begin
            r_ptr_r <= r_ptr_r;
        end
    end

    // Transmitter handoff: byte captured and start pulse raised on the pop
    // edge, so tx_start is high exactly while the FSM sits in START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data_r  <= {DATA_W{1'b0}};
            tx_start_r <= 1'b0;
        end else if (pop_s) begin
            tx_data_r  <= mem_r[r_ptr_r[ADDR_W-1:0]];
            tx_start_r <= 1'b1;
        end else begin
            tx_data_r  <= tx_data_r;
            tx_start_r <= 1'b0;
        end
    end

    // One-cycle flag for a write dropped because the queue was full,
    // regardless of a pop in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= wr_en && full_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo with a simple transmitter model.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] data_in;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       overflow;

    int checks;
    int errors;

    // transmitter model / manual busy control
    logic busy_force;
    logic model_en;
    logic model_busy;
    int   busy_len;
    int   busy_cnt;

    // launch monitor
    logic [7:0] cap_q[$];
    int         start_cnt;
    int         busy_launch_err;

    assign tx_busy = model_en ? model_busy : busy_force;

    uart_tx_fifo #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .data_in  (data_in),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // transmitter model: goes busy the edge after tx_start, for busy_len cycles
    always @(posedge clk) begin
        if (!model_en) begin
            model_busy <= 1'b0;
            busy_cnt   <= 0;
        end else if (busy_cnt == 1) begin
            model_busy <= 1'b0;
            busy_cnt   <= 0;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else if (tx_start) begin
            model_busy <= 1'b1;
            busy_cnt   <= busy_len;
        end
    end

    // capture every launched byte, and flag launches while busy
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            cap_q.push_back(tx_data);
            start_cnt++;
            if (tx_busy) busy_launch_err++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        // power-on reset state
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL por_empty: got %b want 1", empty); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL por_count: got %0d want 0", count); end
        checks++; if (tx_start !== 1'b0 || tx_data !== 8'h00 || overflow !== 1'b0 || full !== 1'b0) begin
            errors++; $display("FAIL por_outputs: start=%b data=%h ovf=%b full=%b want 0/00/0/0", tx_start, tx_data, overflow, full);
        end
        // launch one byte, then hold busy (mid-frame) and queue 3 more
        busy_force = 1'b0;
        wr_en = 1'b1; data_in = 8'h11;
        tick();
        wr_en = 1'b0;
        tick();
        busy_force = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; data_in = 8'h40 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        tick();
        checks++; if (count !== 4'd3 || tx_data !== 8'h11) begin
            errors++; $display("FAIL pre_reset: count=%0d data=%h want 3/11", count, tx_data);
        end
        // asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        checks++; if (empty !== 1'b1 || count !== 4'd0 || tx_data !== 8'h00 || tx_start !== 1'b0) begin
            errors++; $display("FAIL async_reset: empty=%b count=%0d data=%h start=%b want 1/0/00/0", empty, count, tx_data, tx_start);
        end
        busy_force = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (empty !== 1'b1 || count !== 4'd0 || tx_start !== 1'b0) begin
            errors++; $display("FAIL after_reset: empty=%b count=%0d start=%b want 1/0/0", empty, count, tx_start);
        end
    endtask

    task automatic test_single_byte();
        int s0;
        s0 = start_cnt;
        busy_force = 1'b0;
        wr_en = 1'b1; data_in = 8'hA5;
        tick();                      // write edge E0
        wr_en = 1'b0;
        checks++; if (tx_start !== 1'b0 || count !== 4'd1) begin
            errors++; $display("FAIL single_e0: start=%b count=%0d want 0/1", tx_start, count);
        end
        tick();                      // pop edge E1
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'hA5 || count !== 4'd0) begin
            errors++; $display("FAIL single_e1: start=%b data=%h count=%0d want 1/a5/0", tx_start, tx_data, count);
        end
        busy_force = 1'b1;
        tick();
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_pulse_width: start=%b want 0", tx_start); end
        repeat (10) tick();
        busy_force = 1'b0;
        repeat (3) tick();
        checks++; if (start_cnt - s0 !== 1 || tx_data !== 8'hA5) begin
            errors++; $display("FAIL single_one_pulse: pulses=%0d data=%h want 1/a5", start_cnt - s0, tx_data);
        end
    endtask

    task automatic test_fill_overflow();
        busy_force = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; data_in = 8'(i + 1);
            tick();
        end
        checks++; if (full !== 1'b1 || count !== 4'd8 || empty !== 1'b0) begin
            errors++; $display("FAIL fill: full=%b count=%0d empty=%b want 1/8/0", full, count, empty);
        end
        wr_en = 1'b1; data_in = 8'hFF;
        tick();
        wr_en = 1'b0;
        checks++; if (overflow !== 1'b1 || count !== 4'd8) begin
            errors++; $display("FAIL overflow_pulse: ovf=%b count=%0d want 1/8", overflow, count);
        end
        tick();
        checks++; if (overflow !== 1'b0 || count !== 4'd8) begin
            errors++; $display("FAIL overflow_once: ovf=%b count=%0d want 0/8", overflow, count);
        end
    endtask

    task automatic test_drain_order();
        int s0;
        int n;
        cap_q.delete();
        s0 = start_cnt;
        busy_len = 10;
        model_en = 1'b1;
        busy_force = 1'b0;
        n = 0;
        while (start_cnt - s0 < 8 && n < 400) begin tick(); n++; end
        repeat (20) tick();
        checks++; if (start_cnt - s0 !== 8) begin
            errors++; $display("FAIL drain_pulses: got %0d want 8", start_cnt - s0);
        end
        checks++; if (empty !== 1'b1 || count !== 4'd0) begin
            errors++; $display("FAIL drain_empty: empty=%b count=%0d want 1/0", empty, count);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= cap_q.size() || cap_q[i] !== 8'(i + 1)) begin
                errors++; $display("FAIL drain_order[%0d]: got %h want %h", i, (i < cap_q.size()) ? cap_q[i] : 8'hxx, 8'(i + 1));
            end
        end
    endtask

    task automatic test_back_to_back();
        int s0;
        int sent;
        int n;
        int ovf_seen;
        int max_cnt;
        cap_q.delete();
        s0 = start_cnt;
        busy_len = 2;
        model_en = 1'b1;
        sent = 0; n = 0; ovf_seen = 0; max_cnt = 0;
        while ((sent < 20 || start_cnt - s0 < 20) && n < 2000) begin
            if (sent < 20 && !full) begin
                wr_en = 1'b1; data_in = 8'h20 + 8'(sent);
                sent++;
            end else begin
                wr_en = 1'b0;
            end
            tick();
            if (overflow) ovf_seen++;
            if (int'(count) > max_cnt) max_cnt = int'(count);
            n++;
        end
        wr_en = 1'b0;
        repeat (10) tick();
        checks++; if (start_cnt - s0 !== 20) begin
            errors++; $display("FAIL stream_pulses: got %0d want 20", start_cnt - s0);
        end
        checks++; if (ovf_seen !== 0) begin errors++; $display("FAIL stream_overflow: got %0d want 0", ovf_seen); end
        checks++; if (max_cnt !== 8) begin errors++; $display("FAIL stream_max_count: got %0d want 8", max_cnt); end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (i >= cap_q.size() || cap_q[i] !== 8'h20 + 8'(i)) begin
                errors++; $display("FAIL stream_order[%0d]: got %h want %h", i, (i < cap_q.size()) ? cap_q[i] : 8'hxx, 8'h20 + 8'(i));
            end
        end
        checks++; if (busy_launch_err !== 0) begin
            errors++; $display("FAIL launch_while_busy: got %0d want 0", busy_launch_err);
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stream_empty: got %b want 1", empty); end
        model_en = 1'b0;
        tick();
    endtask

    task automatic test_busy_glitch();
        int s0;
        s0 = start_cnt;
        busy_force = 1'b0;
        wr_en = 1'b1; data_in = 8'h5A;
        tick();
        data_in = 8'h61;
        tick();
        data_in = 8'h62;
        tick();
        wr_en = 1'b0;
        repeat (20) tick();
        checks++; if (start_cnt - s0 !== 1 || tx_data !== 8'h5A) begin
            errors++; $display("FAIL glitch_one_launch: pulses=%0d data=%h want 1/5a", start_cnt - s0, tx_data);
        end
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL glitch_count_hold: got %0d want 2", count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (count !== 4'd0 || tx_data !== 8'h00) begin
            errors++; $display("FAIL glitch_reset: count=%0d data=%h want 0/00", count, tx_data);
        end
        wr_en = 1'b1; data_in = 8'h77;
        tick();
        wr_en = 1'b0;
        tick();
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'h77) begin
            errors++; $display("FAIL glitch_recover: start=%b data=%h want 1/77", tx_start, tx_data);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        start_cnt = 0; busy_launch_err = 0;
        rst = 1'b1; wr_en = 1'b0; data_in = 8'h00;
        busy_force = 1'b0; model_en = 1'b0; busy_len = 10;
        test_reset();
        test_single_byte();
        test_fill_overflow();
        test_drain_order();
        test_back_to_back();
        test_busy_glitch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
